// File: rtl/if_fetch_stage.sv
// IF stage and IF/ID register: PC, single-outstanding imem handshake, redirect target.
// Optional performance counters are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wpcir,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_plus4;
    logic [31:0] drop_addr, drop_addr_n;
    logic [31:0] hold_pc4, hold_pc4_n, hold_instr, hold_instr_n;
    logic [31:0] ifid_pc4_n, ifid_instr_n;
    logic        ifid_valid_n;
    logic        redirect, bubble;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = ifid_valid & (NPCOp != 2'b00) & ~wpcir;

    always_comb begin
        case (NPCOp)
            2'b01:   target = ifid_pc4 + {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
            2'b10:   target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
            2'b11:   target = {rs_data[31:2], 2'b00};
            default: target = pc_plus4;
        endcase
    end

    // The request stays up through S_DROP so the abandoned fetch completes cleanly.
    assign imem_req  = ~rst & (state != S_HOLD);
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_n      = state;
        pc_n         = pc;
        drop_addr_n  = drop_addr;
        hold_pc4_n   = hold_pc4;
        hold_instr_n = hold_instr;
        ifid_pc4_n   = ifid_pc4;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;
        bubble       = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_n   = target;
                        bubble = 1'b1;
                    end else if (wpcir) begin
                        hold_pc4_n   = pc_plus4;
                        hold_instr_n = imem_rdata;
                        pc_n         = pc_plus4;
                        state_n      = S_HOLD;
                    end else begin
                        ifid_pc4_n   = pc_plus4;
                        ifid_instr_n = imem_rdata;
                        ifid_valid_n = 1'b1;
                        pc_n         = pc_plus4;
                    end
                end else if (redirect) begin
                    drop_addr_n = pc;
                    pc_n        = target;
                    bubble      = 1'b1;
                    state_n     = S_DROP;
                end else if (!wpcir) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (!wpcir) begin
                    state_n = S_REQ;
                    if (redirect) begin
                        pc_n   = target;
                        bubble = 1'b1;
                    end else begin
                        ifid_pc4_n   = hold_pc4;
                        ifid_instr_n = hold_instr;
                        ifid_valid_n = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) state_n = S_REQ;
                if (redirect) pc_n = target;
                if (!wpcir) bubble = 1'b1;
            end
            default: state_n = S_REQ;
        endcase
        // A bubble keeps ifid_pc4 so a later relative target still has a defined base.
        if (bubble) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop_addr  <= 32'd0;
            hold_pc4   <= 32'd0;
            hold_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drop_addr  <= drop_addr_n;
            hold_pc4   <= hold_pc4_n;
            hold_instr <= hold_instr_n;
            ifid_pc4   <= ifid_pc4_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (wpcir)    stall_cnt <= stall_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
